// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter_if
// Description : Write-request handshake and framebuffer RAM bus shared by the
//               VGA framebuffer arbiter and its neighbours.
//               slave  - arbiter side (accepts writes, drives the RAM).
//               master - writer/RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_fb_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Shares one single-port FB_W x FB_H framebuffer RAM between
//               VGA scan-out (4x4 pixel blocks on 640x480) and a pixel
//               writer. Display fetches own fixed slots two cycles ahead of
//               each 4-pixel group; writes queue in a 2-entry FIFO and drain
//               in the remaining cycles.
//               Optional macro VGA_ARB_VSYNC_WR_EN: drain only while
//               pos_v >= active height (tear-free updates).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int FB_W = 160,
    parameter int FB_H = 120,
    parameter int AW   = 15,
    parameter int DW   = 8
) (
    input  wire logic          clk_pix,
    input  wire logic          rst,
    input  wire logic [9:0]    pos_h,
    input  wire logic [9:0]    pos_v,
    input  wire logic          inrange,
    vga_fb_arbiter_if.slave    bus,
    output logic      [DW-1:0] rgb
);

    localparam logic [9:0]    c_H_ACTIVE = 10'(FB_W * 4);
    localparam logic [9:0]    c_V_ACTIVE = 10'(FB_H * 4);
    localparam logic [9:0]    c_H_WRAP   = 10'd798;   // last two pixels fetch next line
    localparam logic [9:0]    c_V_LAST   = 10'd524;
    localparam logic [AW-1:0] c_FB_SIZE  = AW'(FB_W * FB_H);

    logic [9:0]    w_fx;
    logic [9:0]    w_fy;
    logic          w_slot;
    logic [AW-1:0] w_slot_addr;
    logic          w_drain_ok;
    logic          w_pop;
    logic          w_push;
    logic          w_head_ok;
    logic          w_wr_idx;

    logic          r_fetch_d;
    logic [DW-1:0] r_pix;
    logic [1:0]    r_count;
    logic [AW-1:0] r_fifo_addr [0:1];
    logic [DW-1:0] r_fifo_data [0:1];

    // Fetch position runs two pixels ahead, wrapping into the next line/frame.
    always_comb begin
        if (pos_h < c_H_WRAP) begin
            w_fx = pos_h + 10'd2;
            w_fy = pos_v;
        end else begin
            w_fx = pos_h - c_H_WRAP;
            w_fy = (pos_v == c_V_LAST) ? 10'd0 : pos_v + 10'd1;
        end
    end

    assign w_slot      = (pos_h[1:0] == 2'd2) && (w_fx < c_H_ACTIVE) && (w_fy < c_V_ACTIVE);
    assign w_slot_addr = AW'(w_fy[9:2]) * AW'(FB_W) + AW'(w_fx[9:2]);

`ifdef VGA_ARB_VSYNC_WR_EN
    assign w_drain_ok = (pos_v >= c_V_ACTIVE);
`else
    assign w_drain_ok = 1'b1;
`endif

    // Head is always entry 0; a push lands behind whatever survives this cycle.
    assign bus.wr_ready = (r_count < 2'd2);
    assign w_push       = bus.wr_valid && bus.wr_ready;
    assign w_pop        = !rst && !w_slot && (r_count != 2'd0) && w_drain_ok;
    assign w_head_ok    = (r_fifo_addr[0] < c_FB_SIZE);
    assign w_wr_idx     = w_pop ? r_count[1] : r_count[0];

    // FIFO occupancy; reset discards any queued writes.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: shift on pop, then the push write overrides its slot.
    always_ff @(posedge clk_pix) begin
        if (w_pop) begin
            r_fifo_addr[0] <= r_fifo_addr[1];
            r_fifo_data[0] <= r_fifo_data[1];
        end
        if (w_push) begin
            r_fifo_addr[w_wr_idx] <= bus.wr_addr;
            r_fifo_data[w_wr_idx] <= bus.wr_data;
        end
    end

    // RAM port: display slot wins, then a drained write, else idle at address 0.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (w_slot) begin
            bus.mem_addr = w_slot_addr;
        end else if (w_pop && w_head_ok) begin
            bus.mem_addr  = r_fifo_addr[0];
            bus.mem_we    = 1'b1;
            bus.mem_wdata = r_fifo_data[0];
        end
    end

    // Capture the read data one cycle after each display slot.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_fetch_d <= 1'b0;
            r_pix     <= '0;
        end else begin
            r_fetch_d <= w_slot;
            if (r_fetch_d) begin
                r_pix <= bus.mem_rdata;
            end
        end
    end

    assign rgb = inrange ? r_pix : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Self-checking bench for vga_fb_arbiter. A behavioural model
//               (linear scan index, queue FIFO, RAM array) predicts the RAM
//               port, wr_ready and rgb every cycle; directed literal checks
//               pin the model on the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int c_FB_SIZE = 19200;

    logic       clk_pix = 1'b0;
    logic       rst     = 1'b1;
    logic [9:0] pos_h   = '0;
    logic [9:0] pos_v   = '0;
    logic       inrange = 1'b0;
    logic [7:0] rgb;

    vga_fb_arbiter_if #(.AW(15), .DW(8)) bus ();

    vga_fb_arbiter #(.FB_W(160), .FB_H(120), .AW(15), .DW(8)) dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .pos_h   (pos_h),
        .pos_v   (pos_v),
        .inrange (inrange),
        .bus     (bus),
        .rgb     (rgb)
    );

    always #5 clk_pix = ~clk_pix;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t (h=%0d v=%0d)",
                     name, act, exp, $time, pos_h, pos_v);
        end
    endtask

    // ---------------- RAM model (unwritten words hold a fixed pattern) -----
    bit [7:0] ram_w  [c_FB_SIZE];
    bit       ram_wr [c_FB_SIZE];

    function automatic logic [7:0] init_val(input int a);
        if (a == 0) return 8'hA5;
        return 8'((a * 37 + 11) & 8'hFF) | 8'h01;
    endfunction

    function automatic logic [7:0] ram_rd(input int a);
        return ram_wr[a] ? ram_w[a] : init_val(a);
    endfunction

    always @(posedge clk_pix) begin
        if (int'(bus.mem_addr) < c_FB_SIZE) bus.mem_rdata <= ram_rd(int'(bus.mem_addr));
        else                               bus.mem_rdata <= 8'h00;
        if (bus.mem_we && int'(bus.mem_addr) < c_FB_SIZE) begin
            ram_w[int'(bus.mem_addr)]  <= bus.mem_wdata;
            ram_wr[int'(bus.mem_addr)] <= 1'b1;
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct { int a; int d; } wr_t;
    wr_t q[$];

    bit   model_on = 1'b0;
    int   exp_pix  = 0;
    bit   pend     = 1'b0;
    int   pend_val = 0;
    bit   m_slot, m_pop, m_push;
    int   m_val;
    wr_t  m_item;

    int   t, tf, fx, fy, e_addr, e_wdata, e_rgb;
    bit   e_slot, e_ready, e_drain, e_pop, e_we;

    // Predict this cycle's outputs from position and queue, then compare.
    always @(negedge clk_pix) begin
        t  = int'(pos_v) * 800 + int'(pos_h);
        tf = (t + 2) % (800 * 525);
        fx = tf % 800;
        fy = tf / 800;
        e_slot  = (fx % 4 == 0) && (fx < 640) && (fy < 480);
        e_ready = q.size() < 2;
`ifdef VGA_ARB_VSYNC_WR_EN
        e_drain = (pos_v >= 480);
`else
        e_drain = 1'b1;
`endif
        e_pop   = !rst && !e_slot && (q.size() > 0) && e_drain;
        e_we = 1'b0; e_addr = 0; e_wdata = 0;
        if (e_slot) begin
            e_addr = (fy / 4) * 160 + fx / 4;
        end else if (e_pop && q[0].a < c_FB_SIZE) begin
            e_we = 1'b1; e_addr = q[0].a; e_wdata = q[0].d;
        end
        e_rgb = (pos_h < 640 && pos_v < 480) ? exp_pix : 0;
        if (model_on) begin
            chk("rgb",      int'(rgb),          e_rgb);
            chk("wr_ready", int'(bus.wr_ready), int'(e_ready));
            chk("mem_we",   int'(bus.mem_we),   int'(e_we));
            chk("mem_addr", int'(bus.mem_addr), e_addr);
            if (e_we) chk("mem_wdata", int'(bus.mem_wdata), e_wdata);
        end
        m_slot = e_slot;
        m_val  = e_slot ? int'(ram_rd(e_addr)) : 0;
        m_pop  = e_pop;
        m_push = bus.wr_valid && e_ready;
        m_item = '{a: int'(bus.wr_addr), d: int'(bus.wr_data)};
    end

    always @(posedge clk_pix) begin
        if (rst) begin
            q.delete();
            exp_pix  <= 0;
            pend     <= 1'b0;
            model_on <= 1'b1;
        end else begin
            if (pend) exp_pix <= pend_val;
            pend     <= m_slot;
            pend_val <= m_val;
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(m_item);
        end
    end

    // ---------------- stimulus ----------------
    task automatic go(input int h, input int v, input bit r,
                      input bit wv, input int wa, input int wd);
        @(posedge clk_pix);
        #1;
        pos_h        = 10'(h);
        pos_v        = 10'(v);
        inrange      = (h < 640) && (v < 480);
        rst          = r;
        bus.wr_valid = wv;
        bus.wr_addr  = 15'(wa);
        bus.wr_data  = 8'(wd);
        #2;
    endtask

    initial begin
        int h, v;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Reset
        go(0, 0, 1, 0, 0, 0);
        go(0, 0, 1, 0, 0, 0);
        chk("rst_mem_we", int'(bus.mem_we), 0);
        go(1, 0, 0, 0, 0, 0);
        chk("rst_wr_ready", int'(bus.wr_ready), 1);
        chk("rst_rgb", int'(rgb), 0);

        // Line-wrap fetch of group 0, line 0
        go(798, 524, 0, 0, 0, 0);
        chk("wrap_addr", int'(bus.mem_addr), 0);
        chk("wrap_we", int'(bus.mem_we), 0);
        go(799, 524, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            go(i, 0, 0, 0, 0, 0);
            chk("wrap_rgb", int'(rgb), 8'hA5);
        end

        // Interior fetch
        go(634, 4, 0, 0, 0, 0);
        chk("interior_addr", int'(bus.mem_addr), 319);
`ifndef VGA_ARB_VSYNC_WR_EN
        go(635, 4, 0, 0, 0, 0);
        go(636, 4, 0, 0, 0, 0);
        go(637, 4, 0, 1, 500, 8'h11);
        go(638, 4, 0, 0, 0, 0);
        chk("gap_we", int'(bus.mem_we), 1);
        chk("gap_addr", int'(bus.mem_addr), 500);
        chk("gap_wdata", int'(bus.mem_wdata), 8'h11);

        // Slot collision
        go(1, 10, 0, 1, 100, 8'h3C);
        go(2, 10, 0, 0, 0, 0);
        chk("coll_slot_we", int'(bus.mem_we), 0);
        chk("coll_slot_addr", int'(bus.mem_addr), 321);
        go(3, 10, 0, 0, 0, 0);
        chk("coll_we", int'(bus.mem_we), 1);
        chk("coll_addr", int'(bus.mem_addr), 100);
        chk("coll_wdata", int'(bus.mem_wdata), 8'h3C);

        // Backpressure and out-of-range discard
        go(1, 20, 0, 1, 19200, 8'h99);
        go(2, 20, 0, 1, 777, 8'h5A);
        chk("bp_slot_addr", int'(bus.mem_addr), 801);
        go(3, 20, 0, 1, 778, 8'h5B);
        chk("bp_ready_low", int'(bus.wr_ready), 0);
        chk("bp_discard_we", int'(bus.mem_we), 0);
        go(4, 20, 0, 1, 778, 8'h5B);
        chk("bp_ready_high", int'(bus.wr_ready), 1);
        chk("bp_w1_addr", int'(bus.mem_addr), 777);
        chk("bp_w1_wdata", int'(bus.mem_wdata), 8'h5A);
        go(5, 20, 0, 0, 0, 0);
        chk("bp_w2_we", int'(bus.mem_we), 1);
        chk("bp_w2_addr", int'(bus.mem_addr), 778);
`else
        // Write held during active rows, drained in vertical blanking
        go(100, 100, 0, 1, 1234, 8'h77);
        chk("hold_ready", int'(bus.wr_ready), 1);
        go(101, 100, 0, 0, 0, 0);
        chk("hold_we0", int'(bus.mem_we), 0);
        go(102, 100, 0, 0, 0, 0);
        go(103, 100, 0, 0, 0, 0);
        chk("hold_we1", int'(bus.mem_we), 0);
        go(0, 480, 0, 0, 0, 0);
        chk("vb_we", int'(bus.mem_we), 1);
        chk("vb_addr", int'(bus.mem_addr), 1234);
        chk("vb_wdata", int'(bus.mem_wdata), 8'h77);
`endif

        // Blanking
        go(700, 10, 0, 0, 0, 0);
        chk("blank_rgb", int'(rgb), 0);

        // Reset with a full FIFO
        go(1, 30, 0, 1, 1000, 8'h01);
        go(2, 30, 0, 1, 1001, 8'h02);
        go(3, 30, 1, 0, 0, 0);
        chk("rstfull_we", int'(bus.mem_we), 0);
        go(4, 30, 0, 0, 0, 0);
        chk("rstfull_ready", int'(bus.wr_ready), 1);
        chk("rstfull_we2", int'(bus.mem_we), 0);
        chk("rstfull_rgb", int'(rgb), 0);

        // Randomized scan with jumps, random writes and rare resets
        h = 5; v = 30;
        for (int i = 0; i < 30000; i++) begin
            bit wv, r;
            int wa, wd;
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin v = $urandom_range(0, 524);   h = $urandom_range(0, 799);   end
                    1: begin v = $urandom_range(523, 524); h = $urandom_range(780, 799); end
                    2: begin v = $urandom_range(476, 481); h = $urandom_range(600, 799); end
                    default: begin v = $urandom_range(0, 479); h = $urandom_range(620, 640); end
                endcase
            end else begin
                h++;
                if (h == 800) begin
                    h = 0;
                    v = (v == 524) ? 0 : v + 1;
                end
            end
            wv = ($urandom_range(0, 9) < 4);
            wa = ($urandom_range(0, 15) == 0) ? $urandom_range(19200, 32767)
                                             : $urandom_range(0, 19199);
            wd = $urandom_range(0, 255);
            r  = ($urandom_range(0, 2999) == 0);
            go(h, v, r, wv, wa, wd);
        end

        go(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
